// File: rtl/aes_core_ctrl.sv
`default_nettype none
// ============================================================================
// aes_core_ctrl: start-edge detect, key/text snapshot and round sequencing for
// an iterative AES-128 datapath. Optional irq/irq_ack via AES_CTRL_IRQ_EN.
// Revision: 1.0
// ============================================================================
module aes_core_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [127:0]     aes_key,
  input  logic [127:0]     aes_plaintext,
  input  logic [127:0]     dp_state,
  output logic [127:0]     dp_key,
  output logic [127:0]     dp_text,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic             dp_final,
  output logic [127:0]     aes_ciphertext,
  output logic             DONE,
  output logic             busy,
  output logic             overrun
`ifdef AES_CTRL_IRQ_EN
  ,
  input  logic             irq_ack,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_ROUND   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_ROUNDS);

  state_t             state_q, state_d;
  logic               start_q;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       text_q, text_d;
  logic [127:0]       ct_q, ct_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               irq_q, irq_d;
  logic               go;

  assign go = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    text_d    = text_q;
    ct_d      = ct_q;
    done_d    = done_q;
    // CAPTURE is still busy, so a go there is an overrun too
    overrun_d = overrun_q | (go & (state_q != S_IDLE));
    irq_d     = (state_q == S_CAPTURE);
    case (state_q)
      S_IDLE: begin
        if (go) begin
          key_d   = aes_key;
          text_d  = aes_plaintext;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
`ifdef AES_CTRL_IRQ_EN
        else if (irq_ack) begin
          done_d = 1'b0;
        end
`endif
      end
      S_LOAD: begin
        cnt_d   = IDX_W'(1);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q == C_LAST) state_d = S_CAPTURE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      S_CAPTURE: begin
        ct_d    = dp_state;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      key_q     <= '0;
      text_q    <= '0;
      ct_q      <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      text_q    <= text_d;
      ct_q      <= ct_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign dp_key         = key_q;
  assign dp_text        = text_q;
  assign dp_load        = (state_q == S_LOAD);
  assign dp_round_en    = (state_q == S_ROUND);
  assign dp_round_idx   = (state_q == S_ROUND) ? cnt_q : '0;
  assign dp_final       = (state_q == S_ROUND) && (cnt_q == C_LAST);
  assign aes_ciphertext = ct_q;
  assign DONE           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign overrun        = overrun_q;

`ifdef AES_CTRL_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule
`default_nettype wire
